// File: rtl/wd_sync_counter.sv
// ---------------------------------------------------------------------------
// wd_sync_counter
//   Parameterised synchronous binary up/down modulus counter. Serves as the
//   timebase of the configuration watchdog (q[WIDTH-1] is the timeout flag)
//   and as a generic LPM-style counter.
//
// Parameters
//   LPM_WIDTH      counter width in bits (>=1)
//   LPM_MODULUS    wrap modulus; 0 = full range 2**LPM_WIDTH
//   LPM_DIRECTION  "UP", "DOWN", or "DEFAULT" (direction from updown)
//
// Ports
//   clk     rising-edge clock
//   nreset  synchronous reset, active-low (q -> 0)
//   cnt_en  count enable
//   cin     carry-in; counting needs cnt_en & cin
//   updown  1 = up, 0 = down; only used when LPM_DIRECTION == "DEFAULT"
//   sclr    synchronous clear to 0
//   sset    synchronous set to MAX
//   sload   synchronous load of data (reduced modulo MAX+1)
//   data    load value
//   q       registered count
//   cout    combinational terminal-count carry/borrow-out
// ---------------------------------------------------------------------------
module wd_sync_counter #(
   parameter int unsigned LPM_WIDTH     = 27,
   parameter int unsigned LPM_MODULUS   = 0,
   parameter string       LPM_DIRECTION = "UP"
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 cnt_en,
   input  logic                 cin,
   input  logic                 updown,
   input  logic                 sclr,
   input  logic                 sset,
   input  logic                 sload,
   input  logic [LPM_WIDTH-1:0] data,
   output logic [LPM_WIDTH-1:0] q,
   output logic                 cout
);

   localparam int unsigned W = LPM_WIDTH;

   // Terminal-high value: all ones for full range, else modulus-1.
   localparam logic [W-1:0] MAX = (LPM_MODULUS == 0) ? {W{1'b1}}
                                                      : W'(LPM_MODULUS - 1);

   // Divisor for reducing out-of-range load values (unused for full range).
   localparam logic [W:0] MOD_EXT = (W+1)'((LPM_MODULUS == 0) ? 1 : LPM_MODULUS);

   localparam bit DIR_DEFAULT = (LPM_DIRECTION == "DEFAULT");
   localparam bit DIR_DOWN    = (LPM_DIRECTION == "DOWN");

   logic           up_c;
   logic           count_c;
   logic           at_max_c;
   logic           at_zero_c;
   logic [W-1:0]   load_val_c;
   logic [W-1:0]   next_q_c;

   // Direction and terminal-count decode.
   always_comb begin
      up_c      = DIR_DEFAULT ? updown : !DIR_DOWN;
      count_c   = cnt_en & cin;
      at_max_c  = (q == MAX);
      at_zero_c = (q == '0);
   end

   // Load value wrapped into 0..MAX so counting continues from a legal value.
   always_comb begin
      load_val_c = data;
      if (LPM_MODULUS != 0) begin
         load_val_c = W'({1'b0, data} % MOD_EXT);
      end
   end

   // Next-count selection: sclr > sset > sload > count > hold.
   always_comb begin
      next_q_c = q;
      if (sclr) begin
         next_q_c = '0;
      end else if (sset) begin
         next_q_c = MAX;
      end else if (sload) begin
         next_q_c = load_val_c;
      end else if (count_c) begin
         if (up_c) begin
            next_q_c = at_max_c ? '0 : q + W'(1);
         end else begin
            next_q_c = at_zero_c ? MAX : q - W'(1);
         end
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         q <= '0;
      end else begin
         q <= next_q_c;
      end
   end

   // Terminal count: at MAX going up, at 0 going down, only while counting.
   assign cout = count_c & (up_c ? at_max_c : at_zero_c);

endmodule

// File: tb/tb_wd_sync_counter.sv
// ---------------------------------------------------------------------------
// tb_wd_sync_counter
//   Self-checking bench for wd_sync_counter. Four instances share one set of
//   controls: 4-bit full-range up, 4-bit modulus-10 up, 4-bit updown-driven,
//   and the 27-bit watchdog configuration. Each instance has an arithmetic
//   reference model; directed steps are followed by randomised traffic.
// ---------------------------------------------------------------------------
module tb_wd_sync_counter;

   logic        clk = 1'b0;
   logic        nreset, cnt_en, cin, updown, sclr, sset, sload;
   logic [26:0] data;

   logic [3:0]  qa, qb, qc;
   logic [26:0] qd;
   logic        ca, cb, cc, cd;

   // Model state for each instance.
   logic [63:0] ma, mb, mc, md;

   localparam logic [63:0] MAX_A = 64'd15;
   localparam logic [63:0] MAX_B = 64'd9;
   localparam logic [63:0] MAX_C = 64'd15;
   localparam logic [63:0] MAX_D = 64'h7FF_FFFF;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wd_sync_counter #(.LPM_WIDTH(4), .LPM_MODULUS(0), .LPM_DIRECTION("UP")) u_a (
      .clk(clk), .nreset(nreset), .cnt_en(cnt_en), .cin(cin), .updown(updown),
      .sclr(sclr), .sset(sset), .sload(sload), .data(data[3:0]), .q(qa), .cout(ca));

   wd_sync_counter #(.LPM_WIDTH(4), .LPM_MODULUS(10), .LPM_DIRECTION("UP")) u_b (
      .clk(clk), .nreset(nreset), .cnt_en(cnt_en), .cin(cin), .updown(updown),
      .sclr(sclr), .sset(sset), .sload(sload), .data(data[3:0]), .q(qb), .cout(cb));

   wd_sync_counter #(.LPM_WIDTH(4), .LPM_MODULUS(0), .LPM_DIRECTION("DEFAULT")) u_c (
      .clk(clk), .nreset(nreset), .cnt_en(cnt_en), .cin(cin), .updown(updown),
      .sclr(sclr), .sset(sset), .sload(sload), .data(data[3:0]), .q(qc), .cout(cc));

   wd_sync_counter #(.LPM_WIDTH(27), .LPM_MODULUS(0), .LPM_DIRECTION("UP")) u_d (
      .clk(clk), .nreset(nreset), .cnt_en(cnt_en), .cin(cin), .updown(updown),
      .sclr(sclr), .sset(sset), .sload(sload), .data(data), .q(qd), .cout(cd));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: counts live in 0..maxv, every operation is modular arithmetic.
   function automatic logic [63:0] mnext(input logic [63:0] cur, input logic [63:0] maxv,
                                         input bit up, input int w);
      logic [63:0] dw;
      logic [63:0] m;
      dw = 64'(data) & ((64'd1 << w) - 64'd1);
      m  = maxv + 64'd1;
      if (!nreset)            return 64'd0;
      if (sclr)               return 64'd0;
      if (sset)               return maxv;
      if (sload)              return dw % m;
      if (cnt_en && cin)      return up ? (cur + 64'd1) % m : (cur + maxv) % m;
      return cur;
   endfunction

   function automatic logic [63:0] mcout(input logic [63:0] cur, input logic [63:0] maxv,
                                         input bit up);
      if (!(cnt_en && cin)) return 64'd0;
      return up ? 64'(cur == maxv) : 64'(cur == 64'd0);
   endfunction

   task automatic check_q();
      chk("a_q", 64'(qa), ma);
      chk("b_q", 64'(qb), mb);
      chk("c_q", 64'(qc), mc);
      chk("d_q", 64'(qd), md);
   endtask

   task automatic check_cout();
      chk("a_cout", 64'(ca), mcout(ma, MAX_A, 1'b1));
      chk("b_cout", 64'(cb), mcout(mb, MAX_B, 1'b1));
      chk("c_cout", 64'(cc), mcout(mc, MAX_C, updown));
      chk("d_cout", 64'(cd), mcout(md, MAX_D, 1'b1));
   endtask

   // One clock: check cout for current inputs, take the edge, check q.
   task automatic tick(input bit do_cout);
      #1;
      if (do_cout) check_cout();
      @(posedge clk);
      ma = mnext(ma, MAX_A, 1'b1, 4);
      mb = mnext(mb, MAX_B, 1'b1, 4);
      mc = mnext(mc, MAX_C, updown, 4);
      md = mnext(md, MAX_D, 1'b1, 27);
      #1;
      check_q();
   endtask

   task automatic ctl(input bit en, input bit ci, input bit clr, input bit set,
                      input bit ld, input logic [26:0] d);
      cnt_en = en; cin = ci; sclr = clr; sset = set; sload = ld; data = d;
   endtask

   initial begin
      ma = '0; mb = '0; mc = '0; md = '0;
      nreset = 1'b0; updown = 1'b1;
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 27'd0);

      // Reset edge, then five counts.
      tick(1'b0);
      chk("reset_q", 64'(qa), 64'd0);
      nreset = 1'b1;
      repeat (5) tick(1'b1);
      chk("t1_q5", 64'(qa), 64'd5);
      #1 chk("t1_cout0", 64'(ca), 64'd0);

      // Full-range wrap at 15.
      ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 27'd0); tick(1'b1);
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 27'd0);
      repeat (15) tick(1'b1);
      chk("t2_q15", 64'(qa), 64'd15);
      #1 chk("t2_cout1", 64'(ca), 64'd1);
      tick(1'b1);
      chk("t2_wrap_q", 64'(qa), 64'd0);
      #1 chk("t2_wrap_cout", 64'(ca), 64'd0);

      // Modulus 10 wrap and out-of-range load.
      ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 27'd0); tick(1'b1);
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 27'd0);
      repeat (9) tick(1'b1);
      chk("t3_q9", 64'(qb), 64'd9);
      #1 chk("t3_cout1", 64'(cb), 64'd1);
      tick(1'b1);
      chk("t3_wrap", 64'(qb), 64'd0);
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 27'd12); tick(1'b1);
      chk("t3_load12", 64'(qb), 64'd2);
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 27'd0);
      repeat (8) tick(1'b1);
      chk("t3_after_load", 64'(qb), 64'd0);

      // Control priority.
      ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 27'd0); tick(1'b1);
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 27'd0);
      repeat (7) tick(1'b1);
      chk("t4_q7", 64'(qa), 64'd7);
      ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 27'd0); tick(1'b1);
      chk("t4_sclr_en", 64'(qa), 64'd0);
      ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 27'd0); tick(1'b1);
      chk("t4_sset", 64'(qa), 64'd15);
      chk("t4_sset_mod", 64'(qb), 64'd9);
      chk("t4_sset_wd", 64'(qd), 64'h7FF_FFFF);
      ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 27'd3); tick(1'b1);
      chk("t4_sset_over_load", 64'(qa), 64'd15);
      ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 27'd3); tick(1'b1);
      chk("t4_all_three", 64'(qa), 64'd0);
      nreset = 1'b0;
      ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 27'd5); tick(1'b1);
      chk("t4_reset_wins", 64'(qd), 64'd0);
      nreset = 1'b1;

      // Direction from updown: down from 0 borrows to 15.
      updown = 1'b0;
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 27'd0);
      #1 chk("t5_cout_at0", 64'(cc), 64'd1);
      tick(1'b1);
      chk("t5_down_wrap", 64'(qc), 64'd15);
      chk("t5_up_ignores", 64'(qa), 64'd1);
      repeat (3) tick(1'b1);
      chk("t5_down3", 64'(qc), 64'd12);
      updown = 1'b1;

      // cin gates counting and cout.
      ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 27'd0); tick(1'b1);
      ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'd0);
      #1 chk("t7_cin0_cout", 64'(ca), 64'd0);
      tick(1'b1);
      chk("t7_cin0_hold", 64'(qa), 64'd15);

      // Watchdog: MSB rises 2**26 edges after 0; jump close via load.
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 27'h3FF_FFFD); tick(1'b1);
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 27'd0);
      repeat (2) tick(1'b1);
      chk("t6_msb_low", 64'(qd[26]), 64'd0);
      tick(1'b1);
      chk("t6_msb_rise", 64'(qd[26]), 64'd1);
      chk("t6_q", 64'(qd), 64'h400_0000);
      ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 27'd0);
      repeat (4) tick(1'b1);
      chk("t6_hold", 64'(qd), 64'h400_0000);

      // Randomised traffic against the models.
      for (int i = 0; i < 400; i++) begin
         nreset = ($urandom_range(0, 49) != 0);
         updown = 1'($urandom_range(0, 1));
         ctl(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 11) == 0), 27'($urandom));
         tick(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
